// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the FullUART transmit path: the frame FSM state
// type, frame geometry, line-level constants and the frame builder that
// turns a byte plus line configuration into the 11 slots sent on the wire.
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    // Bit times per frame: start, 8 data/parity slots, parity-or-mark, stop.
    localparam int   FRAME_BITS = 11;

    localparam logic START = 1'b0;
    localparam logic STOP  = 1'b1;
    localparam logic MARK  = 1'b1;

    // Frame vector, bit i is slot i on the line (slot 0 = start bit).
    // 8-bit mode: {stop, P, d7..d0, start}
    // 7-bit mode: {stop, mark, P, d6..d0, start}
    // P is the parity bit when enabled (odd when ohel=1), mark otherwise.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [7:0] data,
        input logic       eight,
        input logic       pen,
        input logic       ohel
    );
        logic par;
        if (eight) begin
            par         = pen ? (^data ^ ohel) : MARK;
            build_frame = {STOP, par, data, START};
        end else begin
            par         = pen ? (^data[6:0] ^ ohel) : MARK;
            build_frame = {STOP, MARK, par, data[6:0], START};
        end
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ----------------------------------------------------------------------------
// uart_bit_timer
// Bit-time timer for the UART transmitter. While enabled it counts
// 0..k-1 and wraps; btu flags the last cycle of each bit time. While
// disabled it is held at 0 so every frame starts on a fresh bit time.
//
// Ports
//   clk  in          system clock
//   rst  in          asynchronous, active-high reset
//   en   in          count enable (engine is sending)
//   k    in  DIV_W   clocks per bit time, must be >= 1
//   btu  out         bit-time-up, high on the count k-1 cycle
// ----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] k,
    output logic             btu
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             at_end;

    assign at_end = (cnt_q == (k - ONE));
    assign btu    = en & at_end;

    // NOTE: combinational next-state logic assigns a default first so no
    // path leaves cnt_d unassigned, which would infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || at_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// ----------------------------------------------------------------------------
// uart_tx_engine
// Transmit-side controller for the FullUART. Accepts one byte per load
// handshake, builds the 11-slot frame from the byte and the line config
// present at the load edge, and shifts it out LSB first, one slot per
// bit time. Loads while a frame is in flight are ignored.
//
// Ports
//   clk      in          system clock
//   rst      in          asynchronous, active-high reset
//   baud_k   in  DIV_W   clocks per bit time, 0 treated as 1
//   eight    in          1 = 8 data bits, 0 = 7 data bits
//   pen      in          parity enable
//   ohel     in          parity sense, 1 = odd, 0 = even
//   tx_data  in  8       byte to send
//   tx_load  in          load request, accepted when tx_rdy is high
//   tx_rdy   out         engine idle, a load will be accepted
//   tx_out   out         serial line, idles at mark (1)
//   tx_done  out         one-cycle pulse at the end of each frame
// ----------------------------------------------------------------------------
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_k,
    input  logic             eight,
    input  logic             pen,
    input  logic             ohel,
    input  logic [7:0]       tx_data,
    input  logic             tx_load,
    output logic             tx_rdy,
    output logic             tx_out,
    output logic             tx_done
);

    localparam logic [DIV_W-1:0] K_MIN     = DIV_W'(1);
    localparam logic [3:0]       LAST_SLOT = 4'(FRAME_BITS - 1);

    tx_state_e             state_q;
    logic [3:0]            bit_cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [DIV_W-1:0]      k_q;
    logic                  tx_rdy_q;
    logic                  tx_done_q;

    logic [FRAME_BITS-1:0] frame_d;
    logic [DIV_W-1:0]      k_d;
    logic                  btu;

    assign frame_d = build_frame(tx_data, eight, pen, ohel);
    assign k_d     = (baud_k == '0) ? K_MIN : baud_k;

    // Timer runs only during SEND and compares against the divisor latched
    // at load, so baud_k changes mid-frame cannot stretch a slot.
    uart_bit_timer #(
        .DIV_W (DIV_W)
    ) u_bit_timer (
        .clk (clk),
        .rst (rst),
        .en  (state_q == SEND),
        .k   (k_q),
        .btu (btu)
    );

    // Shift register holds all ones when idle, so its LSB drives the line
    // directly: mark when idle, start bit the cycle after a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '1;
            k_q       <= K_MIN;
            tx_rdy_q  <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    bit_cnt_q <= '0;
                    if (tx_load) begin
                        shift_q  <= frame_d;
                        k_q      <= k_d;
                        tx_rdy_q <= 1'b0;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    if (btu) begin
                        shift_q <= {MARK, shift_q[FRAME_BITS-1:1]};
                        // Stopping at the last slot keeps the 4-bit
                        // counter from ever wrapping.
                        if (bit_cnt_q == LAST_SLOT) begin
                            bit_cnt_q <= '0;
                            tx_rdy_q  <= 1'b1;
                            tx_done_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_rdy  = tx_rdy_q;
    assign tx_out  = shift_q[0];
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_engine
// Directed bench for uart_tx_engine. Inputs are driven and outputs sampled
// 1 ns after each rising clock edge. Expected frames are hand-computed
// slot vectors (bit i = slot i on the line).
// ----------------------------------------------------------------------------
module tb_uart_tx_engine;

    localparam int DIV_W = 20;

    logic             clk;
    logic             rst;
    logic [DIV_W-1:0] baud_k;
    logic             eight;
    logic             pen;
    logic             ohel;
    logic [7:0]       tx_data;
    logic             tx_load;
    logic             tx_rdy;
    logic             tx_out;
    logic             tx_done;

    int n_checks;
    int n_fail;

    uart_tx_engine #(
        .DIV_W (DIV_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .baud_k  (baud_k),
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .tx_rdy  (tx_rdy),
        .tx_out  (tx_out),
        .tx_done (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte and config for one cycle; returns just after the load edge.
    task automatic load_byte(input logic [7:0] d, input logic e8, input logic pe,
                             input logic oh, input int k);
        tx_data = d;
        eight   = e8;
        pen     = pe;
        ohel    = oh;
        baud_k  = DIV_W'(k);
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
    endtask

    // Watch one frame of 11*k cycles starting just after the load edge.
    // Records the first-cycle value of each slot; counts cycles where the
    // line changed inside a slot, or tx_rdy/tx_done were not low.
    // Optionally presents a competing load (0xFF) at cycle inject_at.
    task automatic capture(input int k, input int inject_at,
                           output logic [10:0] frame, output int glitches);
        int idx;
        frame    = '1;
        glitches = 0;
        for (int s = 0; s < 11; s++) begin
            for (int c = 0; c < k; c++) begin
                idx = s * k + c;
                if (c == 0) frame[s] = tx_out;
                else if (tx_out !== frame[s]) glitches++;
                if (tx_rdy !== 1'b0 || tx_done !== 1'b0) glitches++;
                if (idx == inject_at) begin
                    tx_load = 1'b1;
                    tx_data = 8'hFF;
                end else begin
                    tx_load = 1'b0;
                end
                tick();
            end
        end
        tx_load = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        tx_load = 1'b0;
        tx_data = 8'h00;
        baud_k  = '0;
        eight   = 1'b1;
        pen     = 1'b0;
        ohel    = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({tx_rdy, tx_out, tx_done} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_async: rdy/out/done got %b expected 110", {tx_rdy, tx_out, tx_done});
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({tx_rdy, tx_out, tx_done} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_idle: rdy/out/done got %b expected 110", {tx_rdy, tx_out, tx_done});
        end
    endtask

    // K=4, 8N, 0x55; config is scrambled right after load to prove latching.
    task automatic test_basic_frame();
        logic [10:0] fr;
        int          g;
        load_byte(8'h55, 1'b1, 1'b0, 1'b0, 4);
        baud_k  = DIV_W'(7);
        eight   = 1'b0;
        pen     = 1'b1;
        tx_data = 8'h00;
        capture(4, -1, fr, g);
        n_checks++;
        if (fr !== 11'h6AA) begin
            n_fail++;
            $display("FAIL t1_frame: got %h expected 6aa", fr);
        end
        n_checks++;
        if (g !== 0) begin
            n_fail++;
            $display("FAIL t1_timing: %0d bad cycles, expected 0", g);
        end
        // Now just after edge load+44.
        n_checks++;
        if ({tx_done, tx_rdy, tx_out} !== 3'b111) begin
            n_fail++;
            $display("FAIL t1_done: done/rdy/out got %b expected 111", {tx_done, tx_rdy, tx_out});
        end
        tick();
        n_checks++;
        if ({tx_done, tx_rdy, tx_out} !== 3'b011) begin
            n_fail++;
            $display("FAIL t1_done_pulse: done/rdy/out got %b expected 011", {tx_done, tx_rdy, tx_out});
        end
    endtask

    // K=2, 8-bit, even then odd parity over 0x07 (three ones).
    task automatic test_parity8();
        logic [10:0] fr;
        int          g;
        load_byte(8'h07, 1'b1, 1'b1, 1'b0, 2);
        capture(2, -1, fr, g);
        n_checks++;
        if (fr !== 11'h60E || g !== 0) begin
            n_fail++;
            $display("FAIL t2_even: frame %h glitches %0d expected 60e/0", fr, g);
        end
        n_checks++;
        if (tx_done !== 1'b1) begin
            n_fail++;
            $display("FAIL t2_even_done: got %b expected 1", tx_done);
        end
        tick();
        load_byte(8'h07, 1'b1, 1'b1, 1'b1, 2);
        capture(2, -1, fr, g);
        n_checks++;
        if (fr !== 11'h40E || g !== 0) begin
            n_fail++;
            $display("FAIL t2_odd: frame %h glitches %0d expected 40e/0", fr, g);
        end
        tick();
    endtask

    // K=3, 7-bit, odd parity, 0xC1: d7 dropped, d6..d0 has two ones -> P=1.
    task automatic test_seven_bit();
        logic [10:0] fr;
        int          g;
        load_byte(8'hC1, 1'b0, 1'b1, 1'b1, 3);
        capture(3, -1, fr, g);
        n_checks++;
        if (fr !== 11'h782 || g !== 0) begin
            n_fail++;
            $display("FAIL t3_7bit: frame %h glitches %0d expected 782/0", fr, g);
        end
        n_checks++;
        if (tx_done !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_done: got %b expected 1", tx_done);
        end
        tick();
    endtask

    // Load during SEND is ignored: 0xA5 frame only, one tx_done.
    task automatic test_load_ignored();
        logic [10:0] fr;
        int          g;
        int          extra;
        load_byte(8'hA5, 1'b1, 1'b0, 1'b0, 2);
        capture(2, 10, fr, g);
        n_checks++;
        if (fr !== 11'h74A || g !== 0) begin
            n_fail++;
            $display("FAIL t4_frame: frame %h glitches %0d expected 74a/0", fr, g);
        end
        n_checks++;
        if (tx_done !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_done: got %b expected 1", tx_done);
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tx_done !== 1'b0 || tx_out !== 1'b1 || tx_rdy !== 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL t4_no_second_frame: %0d non-idle cycles, expected 0", extra);
        end
    endtask

    // Load in the tx_done cycle: one mark cycle, then the next start bit.
    task automatic test_back_to_back();
        logic [10:0] fr;
        int          g;
        load_byte(8'h12, 1'b1, 1'b0, 1'b0, 2);
        capture(2, -1, fr, g);
        n_checks++;
        if (fr !== 11'h624 || g !== 0) begin
            n_fail++;
            $display("FAIL t5_first: frame %h glitches %0d expected 624/0", fr, g);
        end
        n_checks++;
        if ({tx_done, tx_rdy, tx_out} !== 3'b111) begin
            n_fail++;
            $display("FAIL t5_gap: done/rdy/out got %b expected 111", {tx_done, tx_rdy, tx_out});
        end
        load_byte(8'h9C, 1'b1, 1'b1, 1'b0, 2);
        n_checks++;
        if ({tx_rdy, tx_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL t5_start: rdy/out got %b expected 00", {tx_rdy, tx_out});
        end
        capture(2, -1, fr, g);
        n_checks++;
        if (fr !== 11'h538 || g !== 0) begin
            n_fail++;
            $display("FAIL t5_second: frame %h glitches %0d expected 538/0", fr, g);
        end
        n_checks++;
        if (tx_done !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_done: got %b expected 1", tx_done);
        end
        tick();
    endtask

    // Async reset mid-frame, then a clean frame with baud_k=0 (K=1).
    task automatic test_reset_midframe();
        logic [10:0] fr;
        int          g;
        load_byte(8'h3C, 1'b1, 1'b0, 1'b0, 4);
        repeat (17) tick();
        n_checks++;
        if (tx_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_busy: rdy got %b expected 0", tx_rdy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({tx_rdy, tx_out, tx_done} !== 3'b110) begin
            n_fail++;
            $display("FAIL t6_reset: rdy/out/done got %b expected 110", {tx_rdy, tx_out, tx_done});
        end
        tick();
        rst = 1'b0;
        tick();
        load_byte(8'h81, 1'b1, 1'b0, 1'b0, 0);
        capture(1, -1, fr, g);
        n_checks++;
        if (fr !== 11'h702 || g !== 0) begin
            n_fail++;
            $display("FAIL t6_k0_frame: frame %h glitches %0d expected 702/0", fr, g);
        end
        n_checks++;
        if ({tx_done, tx_rdy, tx_out} !== 3'b111) begin
            n_fail++;
            $display("FAIL t6_k0_done: done/rdy/out got %b expected 111", {tx_done, tx_rdy, tx_out});
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_frame();
        test_parity8();
        test_seven_bit();
        test_load_ignored();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
